data_mem_sequencer: RTL
=======================

Name: data_mem_sequencer

Overview:
- Memory-stage access unit between the pipeline's MEM stage and the data segment port of the segmented memory.
- The data port is byte-wide: only the low 8 bits of its read data are meaningful, and it accepts one byte write per cycle. This block splits 16-bit loads/stores into two little-endian byte accesses.
- It range-checks each request against the data segment, stalls the pipeline while busy, and returns a zero-extended 16-bit result.

Parameters:
- WIDTH, 16, address and data width.
- RAMSIZE, 4, bytes per data bank. The data segment spans 3*RAMSIZE bytes (addresses 0 .. 3*RAMSIZE-1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  MEM stage presents an access.
- req_write  in  1  1=store, 0=load.
- req_word  in  1  1=16-bit access, 0=byte access.
- req_addr  in  WIDTH  byte address.
- req_wdata  in  WIDTH  store data; byte store uses [7:0].
- stall  out  1  hold upstream pipeline registers.
- resp_valid  out  1  one-cycle pulse; access complete.
- resp_rdata  out  WIDTH  load result, zero-extended; 0 for stores.
- resp_err  out  1  valid with resp_valid; access was out of range.
- mem_we  out  1  to memory data-port write enable.
- mem_addr  out  WIDTH  to memory data-port address.
- mem_wd  out  WIDTH  to memory data-port write data; upper byte always 0.
- mem_rd  in  WIDTH  from memory data port; only [7:0] used. Combinational read of the current mem_addr.

Behaviour:
- Reset values: state=IDLE; resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_addr=0, mem_wd=0. stall is forced to 0 while reset=1.
- States: IDLE, BYTE0, BYTE1, RESP.
- IDLE:
  - stall = req_valid.
  - When req_valid=1, capture write, word, addr and wdata.
  - Compute last = addr + word using WIDTH+1-bit arithmetic.
  - If last >= 3*RAMSIZE, go to RESP with err_q=1 and issue no memory cycle.
  - Otherwise clear the data register and go to BYTE0.
- BYTE0:
  - mem_addr = addr_q.
  - Store: mem_we=1, mem_wd = {0, wdata_q[7:0]}.
  - Load: mem_we=0; latch mem_rd[7:0] into rdata_q[7:0] at the clock edge.
  - Next state: BYTE1 if word_q, else RESP. stall=1.
- BYTE1:
  - mem_addr = addr_q+1.
  - Store: mem_we=1, mem_wd = {0, wdata_q[15:8]}.
  - Load: latch mem_rd[7:0] into rdata_q[15:8].
  - Next state: RESP. stall=1.
- RESP:
  - resp_valid=1, resp_rdata = rdata_q (0 for stores and errors), resp_err = err_q.
  - stall=0, so upstream advances this cycle.
  - req_valid in RESP belongs to the retiring request and is ignored.
  - Next state: IDLE.
- In IDLE and RESP: mem_we=0, mem_addr=0, mem_wd=0.
- Latency from the accept cycle T:
  - byte access: resp at T+2.
  - word access: resp at T+3.
  - range error: resp at T+1.
- resp_rdata and resp_err are meaningful only while resp_valid=1. Outside RESP they are driven to 0.
- Wrap-around: addr 0xFFFF with word=1 gives last=0x10000, which is out of range and flagged as an error. The address never wraps to 0.
- Misaligned word accesses are legal (e.g. addr=3 spans banks 0/1).
- Reset mid-operation: return to IDLE next edge; mem_we=0 from that cycle. A word store interrupted after BYTE0 leaves its low byte written. This is accepted behaviour.
- req_* inputs are sampled only in IDLE; changes during BYTE0/BYTE1 have no effect.

Test Plan (RAMSIZE=4):
- Byte store addr=5, wdata=0x12AB, then byte load addr=5 -> store: mem_we=1 one cycle with mem_addr=5, mem_wd=0x00AB; load: resp at T+2, resp_rdata=0x00AB, resp_err=0.
- Word store addr=3, wdata=0xBEEF, then word load addr=3 -> two write cycles (3→0xEF, 4→0xBE); load resp_rdata=0xBEEF at T+3; stall=1 for cycles T..T+2, 0 at T+3.
- Word load addr=11 and byte load addr=12 -> resp at T+1 with resp_err=1, resp_rdata=0, mem_we never asserted.
- Word store addr=0xFFFF -> resp_err=1 at T+1, no memory write.
- Word store addr=0, wdata=0x5566, reset asserted in the BYTE1 cycle -> next cycle IDLE, mem_we=0, no resp_valid; byte 0 reads 0x66, byte 1 unchanged.
- Back-to-back: byte load addr=2 held through RESP, new request next cycle -> exactly one resp_valid per request, no request dropped or duplicated.

Source files
------------

// File: rtl/data_mem_sequencer.sv
// MEM-stage access unit for the byte-wide data segment port.
// Splits 16-bit loads/stores into two little-endian byte cycles, range-checks, and stalls while busy.
module data_mem_sequencer #(
    parameter int WIDTH   = 16,
    parameter int RAMSIZE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic             req_write,
    input  logic             req_word,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             stall,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_err,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wd,
    input  logic [WIDTH-1:0] mem_rd
);
    // state | meaning
    // IDLE  | waiting for a request; range check happens on accept
    // BYTE0 | low byte access at addr_q
    // BYTE1 | high byte access at addr_q+1 (word accesses only)
    // RESP  | one-cycle response; upstream advances
    typedef enum logic [1:0] {IDLE, BYTE0, BYTE1, RESP} state_t;

    localparam logic [WIDTH:0] SEG_END = (WIDTH+1)'(3 * RAMSIZE);

    state_t           state, state_next;
    logic             write_q, word_q, err_q;
    logic [WIDTH-1:0] addr_q, wdata_q, rdata_q;
    logic [WIDTH:0]   last;
    logic             range_err;
    logic             unused_rd_hi;

    // Extra bit keeps 0xFFFF+1 from wrapping back into the segment.
    assign last         = {1'b0, req_addr} + {{WIDTH{1'b0}}, req_word};
    assign range_err    = (last >= SEG_END);
    assign unused_rd_hi = ^mem_rd[WIDTH-1:8];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            write_q <= 1'b0;
            word_q  <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        write_q <= req_write;
                        word_q  <= req_word;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        err_q   <= range_err;
                        rdata_q <= '0;
                    end
                end
                BYTE0: begin
                    if (!write_q) begin
                        rdata_q[7:0] <= mem_rd[7:0];
                    end
                end
                BYTE1: begin
                    if (!write_q) begin
                        rdata_q[15:8] <= mem_rd[7:0];
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        resp_err   = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wd     = '0;
        case (state)
            IDLE: begin
                stall = req_valid;
                if (req_valid) begin
                    state_next = range_err ? RESP : BYTE0;
                end
            end
            BYTE0: begin
                stall    = 1'b1;
                mem_addr = addr_q;
                mem_we   = write_q;
                if (write_q) begin
                    mem_wd = {{(WIDTH-8){1'b0}}, wdata_q[7:0]};
                end
                state_next = word_q ? BYTE1 : RESP;
            end
            BYTE1: begin
                stall    = 1'b1;
                mem_addr = addr_q + WIDTH'(1);
                mem_we   = write_q;
                if (write_q) begin
                    mem_wd = {{(WIDTH-8){1'b0}}, wdata_q[15:8]};
                end
                state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_rdata = rdata_q;
                resp_err   = err_q;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Outputs are quiet during reset so an interrupted store writes nothing more.
        if (reset) begin
            stall      = 1'b0;
            resp_valid = 1'b0;
            resp_rdata = '0;
            resp_err   = 1'b0;
            mem_we     = 1'b0;
            mem_addr   = '0;
            mem_wd     = '0;
        end
    end
endmodule
